// File: rtl/npu_pkg.sv
// Shared NPU datapath types: activation element type and signed max helper.
package npu_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic signed [DATA_W-1:0] act_t;

  function automatic act_t smax(input act_t a, input act_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/max2_s.sv
// Combinational signed two-input maximum over activation elements.
module max2_s
  import npu_pkg::*;
(
  input  act_t i_a,
  input  act_t i_b,
  output act_t o_max
);

  assign o_max = smax(i_a, i_b);

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool: row-major element stream in, pooled stream out.
// Even rows fold column pairs into a half-row line buffer; odd rows merge and emit.
module maxpool2x2_stream
  import npu_pkg::*;
#(
  parameter int unsigned ROWS = 10,
  parameter int unsigned COLS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  act_t in_data,
  input  logic in_valid,
  output logic in_ready,
  output act_t out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic frame_done
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned HALF  = COLS / 2;
  localparam int unsigned IDX_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  act_t             r_h;
  act_t             r_line_buf [HALF];
  act_t             r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_frame_done;

  logic             w_in_acc;
  logic             w_out_acc;
  logic             w_odd_row;
  logic             w_odd_col;
  logic             w_last_row;
  logic             w_last_col;
  logic             w_produce;
  logic [IDX_W-1:0] w_idx;
  act_t             w_pair;
  act_t             w_merged;

  // Single-entry output register: accept input whenever the held result is absent or draining.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_in_acc   = in_valid && in_ready;
  assign w_out_acc  = r_out_valid && out_ready;
  assign w_odd_row  = r_row[0];
  assign w_odd_col  = r_col[0];
  assign w_last_row = (r_row == ROW_W'(ROWS - 1));
  assign w_last_col = (r_col == COL_W'(COLS - 1));
  assign w_produce  = w_in_acc && w_odd_col && w_odd_row;
  assign w_idx      = IDX_W'(r_col >> 1);

  max2_s u_pair_max (
    .i_a   (r_h),
    .i_b   (in_data),
    .o_max (w_pair)
  );

  max2_s u_merge_max (
    .i_a   (r_line_buf[w_idx]),
    .i_b   (w_pair),
    .o_max (w_merged)
  );

  // Position counters and horizontal hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_h   <= '0;
    end else if (w_in_acc) begin
      if (!w_odd_col) begin
        r_h <= in_data;
      end
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Line buffer is always written on an even row before the odd row reads it, so no reset.
  always_ff @(posedge clk) begin
    if (w_in_acc && w_odd_col && !w_odd_row) begin
      r_line_buf[w_idx] <= w_pair;
    end
  end

  // Output register; data/last only move when a new result is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_out_acc && r_out_last;
      if (w_produce) begin
        r_out_data  <= w_merged;
        r_out_valid <= 1'b1;
        r_out_last  <= w_last_row && w_last_col;
      end else if (w_out_acc) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;

endmodule
